dmem_access_unit: RTL and testbench
===================================

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 15, the maximum number of BUSY cycles to wait for dmem_ack before aborting.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 PC_plus_4_eo, ALU_result_eo, Read_data2_eo  in  32 each  EX/MEM values; ALU_result_eo is the byte address and Read_data2_eo is the store data.
REQ-006 Rd_eo  in  5 / Wr_data_sel_eo  in  2 / Reg_wr_eo, Mem_rd_eo, Mem_wr_eo  in  1 each  EX/MEM control fields.
REQ-007 dmem_req  out  1 / dmem_we  out  1 / dmem_addr  out  32 / dmem_wdata  out  32  data-memory request bus (registered).
REQ-008 dmem_ack  in  1 / dmem_rdata  in  32  data-memory response; dmem_rdata is valid only while dmem_ack=1.
REQ-009 stall  out  1  combinational hold request that freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-010 Read_data_mo, ALU_result_mo, PC_plus_4_mo  out  32 / Rd_mo  out  5 / Wr_data_sel_mo  out  2 / Reg_wr_mo  out  1  MEM/WB register.
REQ-011 misalign_err, bus_err  out  1 each  one-cycle error pulses (registered).

Function
REQ-012 mem_op SHALL equal Mem_rd_eo | Mem_wr_eo; when both are 1, the operation SHALL be a write (Mem_wr_eo has priority).
REQ-013 FSM states SHALL be IDLE and BUSY, plus a wait counter of ceil(log2(TIMEOUT+1)) bits.
REQ-014 IDLE with mem_op=1 and ALU_result_eo[1:0]=00 SHALL transition to BUSY at the next edge, registering dmem_req=1, dmem_we=Mem_wr_eo, dmem_addr=ALU_result_eo, dmem_wdata=Read_data2_eo, and clearing the counter.
REQ-015 In BUSY, dmem_addr, dmem_we and dmem_wdata SHALL be held stable while dmem_req=1.
REQ-016 BUSY with dmem_ack=1 SHALL return to IDLE at that edge, deassert dmem_req, and load MEM/WB from the EX/MEM inputs; Read_data_mo=dmem_rdata for a read and 0 for a write.
REQ-017 BUSY with dmem_ack=0 SHALL increment the counter; when the counter equals TIMEOUT-1 with no ack, the block SHALL deassert dmem_req, return to IDLE, pulse bus_err for one cycle, and load a bubble into MEM/WB.
REQ-018 stall SHALL equal (IDLE & aligned mem_op) | (BUSY & !dmem_ack & !timeout_hit), and SHALL be 0 in the ack cycle and in the timeout cycle.
REQ-019 On every edge with stall=1, MEM/WB SHALL load a bubble: Reg_wr_mo=0, all other MEM/WB outputs hold their values.
REQ-020 A non-memory op with stall=0 SHALL pass EX/MEM to MEM/WB in one cycle, with Read_data_mo=0.
REQ-021 A misaligned mem_op (ALU_result_eo[1:0]!=00) in IDLE SHALL issue no bus request and no stall, SHALL pulse misalign_err for one cycle, and SHALL load a MEM/WB bubble.
REQ-022 dmem_ack while in IDLE SHALL be ignored, with no state or output change.
REQ-023 Back-to-back mem ops SHALL be supported: after an ack edge with the next mem_op present, the FSM SHALL re-enter BUSY one cycle later (minimum 2 cycles per access).
REQ-024 Load latency SHALL be: with ack arriving k cycles after dmem_req rises (k≥0), the result appears on Read_data_mo k+2 edges after the op arrives on EX/MEM.

Reset
REQ-025 reset=1 SHALL immediately force state=IDLE, counter=0, and every registered output to 0; stall SHALL be 0 while reset=1.
REQ-026 Reset asserted during BUSY SHALL abandon the access, with dmem_req=0 immediately and no error pulse; a late dmem_ack after reset SHALL be ignored (REQ-022).
REQ-027 The first mem_op after reset is released SHALL be handled normally from IDLE.

Verification
REQ-028 Aligned load, addr=0x00000100, ack after 2 cycles with rdata=0xDEADBEEF -> stall=1 for 3 cycles, Read_data_mo=0xDEADBEEF, Reg_wr_mo=1.
REQ-029 Store, addr=0x00000200, data=0x12345678, ack after 0 cycles -> dmem_we=1, dmem_wdata=0x12345678, stall=1 for 1 cycle, Read_data_mo=0.
REQ-030 Load at addr=0x00000102 -> no dmem_req, misalign_err=1 for 1 cycle, Reg_wr_mo=0, stall=0.
REQ-031 Load with no ack, TIMEOUT=15 -> dmem_req high for 15 cycles, then bus_err pulse, stall released, Reg_wr_mo=0.
REQ-032 reset asserted in the 2nd BUSY cycle, then ack pulsed -> dmem_req=0 immediately, all outputs 0, no error pulses, ack ignored.
REQ-033 ALU op (Reg_wr_eo=1, ALU_result_eo=0x00000055), then a load, then an ALU op -> MEM/WB sequence: ALU op, bubble(s), load, ALU op, in order.

Source files
------------

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: issues word accesses on the dmem bus,
// stalls the pipeline while waiting for ack, and drives the MEM/WB register.
module dmem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_plus_4_eo,
    input  logic [31:0] ALU_result_eo,
    input  logic [31:0] Read_data2_eo,
    input  logic [4:0]  Rd_eo,
    input  logic [1:0]  Wr_data_sel_eo,
    input  logic        Reg_wr_eo,
    input  logic        Mem_rd_eo,
    input  logic        Mem_wr_eo,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] Read_data_mo,
    output logic [31:0] ALU_result_mo,
    output logic [31:0] PC_plus_4_mo,
    output logic [4:0]  Rd_mo,
    output logic [1:0]  Wr_data_sel_mo,
    output logic        Reg_wr_mo,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;

    logic        mem_op_s, aligned_s, timeout_hit_s;
    logic        req_s, we_s, mis_s, berr_s, reg_wr_s;
    logic [31:0] addr_s, wdata_s, read_data_s, alu_s, pc4_s;
    logic [4:0]  rd_s;
    logic [1:0]  sel_s;

    assign mem_op_s      = Mem_rd_eo | Mem_wr_eo;
    assign aligned_s     = (ALU_result_eo[1:0] == 2'b00);
    assign timeout_hit_s = (state_r == BUSY) && !dmem_ack && (cnt_r == CNT_LAST);

    // Hold request to the upstream pipeline; never asserted while in reset.
    assign stall = !reset && (((state_r == IDLE) && mem_op_s && aligned_s) ||
                              ((state_r == BUSY) && !dmem_ack && !timeout_hit_s));

    // Next-state and next-value logic for the FSM, bus and MEM/WB registers.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        req_s       = dmem_req;
        we_s        = dmem_we;
        addr_s      = dmem_addr;
        wdata_s     = dmem_wdata;
        mis_s       = 1'b0;
        berr_s      = 1'b0;
        read_data_s = Read_data_mo;
        alu_s       = ALU_result_mo;
        pc4_s       = PC_plus_4_mo;
        rd_s        = Rd_mo;
        sel_s       = Wr_data_sel_mo;
        reg_wr_s    = Reg_wr_mo;
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    reg_wr_s = 1'b0;
                    if (aligned_s) begin
                        state_s = BUSY;
                        cnt_s   = '0;
                        req_s   = 1'b1;
                        we_s    = Mem_wr_eo;
                        addr_s  = ALU_result_eo;
                        wdata_s = Read_data2_eo;
                    end else begin
                        mis_s = 1'b1;
                    end
                end else begin
                    read_data_s = 32'h0000_0000;
                    alu_s       = ALU_result_eo;
                    pc4_s       = PC_plus_4_eo;
                    rd_s        = Rd_eo;
                    sel_s       = Wr_data_sel_eo;
                    reg_wr_s    = Reg_wr_eo;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_s     = IDLE;
                    req_s       = 1'b0;
                    // EX/MEM is frozen during the access, so it still holds this op.
                    read_data_s = dmem_we ? 32'h0000_0000 : dmem_rdata;
                    alu_s       = ALU_result_eo;
                    pc4_s       = PC_plus_4_eo;
                    rd_s        = Rd_eo;
                    sel_s       = Wr_data_sel_eo;
                    reg_wr_s    = Reg_wr_eo;
                end else if (timeout_hit_s) begin
                    state_s  = IDLE;
                    cnt_s    = '0;
                    req_s    = 1'b0;
                    berr_s   = 1'b1;
                    reg_wr_s = 1'b0;
                end else begin
                    cnt_s    = cnt_r + CW'(1);
                    reg_wr_s = 1'b0;
                end
            end
            default: begin
                state_s  = IDLE;
                cnt_s    = '0;
                req_s    = 1'b0;
                reg_wr_s = 1'b0;
            end
        endcase
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'h0000_0000;
            dmem_wdata     <= 32'h0000_0000;
            misalign_err   <= 1'b0;
            bus_err        <= 1'b0;
            Read_data_mo   <= 32'h0000_0000;
            ALU_result_mo  <= 32'h0000_0000;
            PC_plus_4_mo   <= 32'h0000_0000;
            Rd_mo          <= 5'd0;
            Wr_data_sel_mo <= 2'd0;
            Reg_wr_mo      <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            dmem_req       <= req_s;
            dmem_we        <= we_s;
            dmem_addr      <= addr_s;
            dmem_wdata     <= wdata_s;
            misalign_err   <= mis_s;
            bus_err        <= berr_s;
            Read_data_mo   <= read_data_s;
            ALU_result_mo  <= alu_s;
            PC_plus_4_mo   <= pc4_s;
            Rd_mo          <= rd_s;
            Wr_data_sel_mo <= sel_s;
            Reg_wr_mo      <= reg_wr_s;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: vector table plus scoreboard of
// expected MEM/WB records, and a hand-written reset-during-access sequence.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_plus_4_eo, ALU_result_eo, Read_data2_eo;
    logic [4:0]  Rd_eo;
    logic [1:0]  Wr_data_sel_eo;
    logic        Reg_wr_eo, Mem_rd_eo, Mem_wr_eo;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] Read_data_mo, ALU_result_mo, PC_plus_4_mo;
    logic [4:0]  Rd_mo;
    logic [1:0]  Wr_data_sel_mo;
    logic        Reg_wr_mo, misalign_err, bus_err;

    dmem_access_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .PC_plus_4_eo(PC_plus_4_eo), .ALU_result_eo(ALU_result_eo), .Read_data2_eo(Read_data2_eo),
        .Rd_eo(Rd_eo), .Wr_data_sel_eo(Wr_data_sel_eo), .Reg_wr_eo(Reg_wr_eo),
        .Mem_rd_eo(Mem_rd_eo), .Mem_wr_eo(Mem_wr_eo),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .Read_data_mo(Read_data_mo), .ALU_result_mo(ALU_result_mo), .PC_plus_4_mo(PC_plus_4_mo),
        .Rd_mo(Rd_mo), .Wr_data_sel_mo(Wr_data_sel_mo), .Reg_wr_mo(Reg_wr_mo),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mrd, mwr, regwr;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] alu, pc4, data2, rdata;
        int          ack_k;      // ack this many cycles after req rises; -1 = never
        bit          ack_idle;   // drive a stray ack while idle
        int          exp_stall, exp_req;
        bit          exp_we, exp_mis, exp_berr, exp_bubble;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic [31:0] read_data, alu, pc4;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic        reg_wr;
    } mw_t;

    vec_t vecs[10];
    mw_t  sb_q[$];
    mw_t  last_mw;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mw_t cur_mw();
        return '{Read_data_mo, ALU_result_mo, PC_plus_4_mo, Rd_mo, Wr_data_sel_mo, Reg_wr_mo};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int   stall_cnt = 0, req_cnt = 0, busy = 0, guard = 0;
        bit   done = 0, seen_mis = 0, seen_berr = 0, bub_ok = 1;
        logic cap_we = 1'b0;
        logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0;
        mw_t  exp;
        @(negedge clk);
        Mem_rd_eo = v.mrd; Mem_wr_eo = v.mwr; Reg_wr_eo = v.regwr;
        Rd_eo = v.rd; Wr_data_sel_eo = v.sel; ALU_result_eo = v.alu;
        PC_plus_4_eo = v.pc4; Read_data2_eo = v.data2;
        if (v.exp_bubble) begin
            exp = last_mw;
            exp.reg_wr = 1'b0;
        end else begin
            exp = '{v.exp_rdata, v.alu, v.pc4, v.rd, v.sel, v.regwr};
        end
        last_mw = exp;
        sb_q.push_back(exp);
        while (!done && guard < 40) begin
            guard++;
            if (dmem_req) begin
                cap_addr = dmem_addr; cap_we = dmem_we; cap_wdata = dmem_wdata;
                if (v.ack_k >= 0 && busy == v.ack_k) begin
                    dmem_ack = 1'b1; dmem_rdata = v.rdata;
                end else begin
                    dmem_ack = 1'b0; dmem_rdata = $urandom;
                end
                busy++;
            end else begin
                dmem_ack = v.ack_idle; dmem_rdata = $urandom;
            end
            #1;
            if (dmem_req) req_cnt++;
            if (stall) stall_cnt++;
            else done = 1;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (misalign_err) seen_mis = 1;
            if (bus_err) seen_berr = 1;
            if (!done) begin
                if (Reg_wr_mo !== 1'b0) bub_ok = 0;
                @(negedge clk);
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL vec%0d_guard: op never completed within %0d cycles", idx, guard);
        end
        chk($sformatf("vec%0d_mw", idx), 128'(cur_mw()), 128'(sb_q.pop_front()));
        chk($sformatf("vec%0d_stall", idx), 128'(stall_cnt), 128'(v.exp_stall));
        chk($sformatf("vec%0d_req", idx), 128'(req_cnt), 128'(v.exp_req));
        chk($sformatf("vec%0d_errs", idx), 128'({seen_mis, seen_berr, bub_ok}),
            128'({v.exp_mis, v.exp_berr, 1'b1}));
        if (v.exp_req > 0)
            chk($sformatf("vec%0d_bus", idx), {63'h0, cap_we, cap_addr, cap_wdata},
                {63'h0, v.exp_we, v.alu, v.data2});
    endtask

    initial begin
        vecs[0] = '{0,0,1,5'd1,2'd0,32'h55,32'h1004,32'h0,32'h0,-1,0, 0,0,0,0,0,0,32'h0};
        vecs[1] = '{1,0,1,5'd2,2'd1,32'h100,32'h1008,32'hAAAA5555,32'hDEADBEEF,2,0, 3,3,0,0,0,0,32'hDEADBEEF};
        vecs[2] = '{0,0,1,5'd3,2'd0,32'h77,32'h100C,32'h0,32'h0,-1,1, 0,0,0,0,0,0,32'h0};
        vecs[3] = '{0,1,0,5'd0,2'd0,32'h200,32'h1010,32'h12345678,32'h0,0,0, 1,1,1,0,0,0,32'h0};
        vecs[4] = '{1,0,1,5'd4,2'd1,32'h102,32'h1014,32'h0,32'h0,-1,0, 0,0,0,1,0,1,32'h0};
        vecs[5] = '{1,0,1,5'd5,2'd1,32'h180,32'h1018,32'h0,32'h0,-1,0, 15,15,0,0,1,1,32'h0};
        vecs[6] = '{1,1,1,5'd6,2'd0,32'h300,32'h101C,32'hFEEDFACE,32'h0BADF00D,1,0, 2,2,1,0,0,0,32'h0};
        vecs[7] = '{1,0,1,5'd7,2'd1,32'h104,32'h1020,32'h0,32'hCAFEF00D,0,0, 1,1,0,0,0,0,32'hCAFEF00D};
        vecs[8] = '{0,0,1,5'd8,2'd2,32'h12345679,32'h1024,32'h0,32'h0,-1,1, 0,0,0,0,0,0,32'h0};
        vecs[9] = '{1,0,1,5'd9,2'd1,32'h3FC,32'h1028,32'h0,32'h13579BDF,4,0, 5,5,0,0,0,0,32'h13579BDF};

        reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        PC_plus_4_eo = 32'h0; ALU_result_eo = 32'h0; Read_data2_eo = 32'h0;
        Rd_eo = 5'd0; Wr_data_sel_eo = 2'd0; Reg_wr_eo = 1'b0; Mem_rd_eo = 1'b0; Mem_wr_eo = 1'b0;
        last_mw = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, misalign_err, bus_err,
                            Read_data_mo, Reg_wr_mo}, 128'h0);
        chk("reset_mw", 128'(cur_mw()), 128'h0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset asserted in the second BUSY cycle, then a late ack.
        @(negedge clk);
        Mem_rd_eo = 1'b1; Mem_wr_eo = 1'b0; Reg_wr_eo = 1'b1; ALU_result_eo = 32'h400;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_pre_req", 128'(dmem_req), 128'h1);
        reset = 1'b1;
        #1;
        chk("rst_async", {dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, misalign_err, bus_err},
            128'h0);
        chk("rst_mw", 128'(cur_mw()), 128'h0);
        @(negedge clk);
        Mem_rd_eo = 1'b0; Reg_wr_eo = 1'b0; ALU_result_eo = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h5A5A5A5A;
        #1;
        chk("late_ack_stall", 128'(stall), 128'h0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("late_ack_ignored", {dmem_req, misalign_err, bus_err, Read_data_mo, Reg_wr_mo}, 128'h0);
        last_mw = '0;

        run_vec(1, vecs[1]);
        run_vec(0, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
